// File: rtl/seq_array_multiplier.sv
// Sequential shift-add multiplier, WIDTH cycles/op, valid/ready in and out.
// Optional two's-complement mode when SEQ_MUL_SIGNED_EN is defined.
//
// Ports:
//   clk, rst_n     clock, async active-low reset
//   in_valid       operands a/b/is_signed valid
//   in_ready       high in IDLE, operands accepted
//   a, b           multiplicand, multiplier (WIDTH bits)
//   is_signed      signed request (used only with SEQ_MUL_SIGNED_EN)
//   out_valid      product valid (DONE state)
//   out_ready      downstream accepts product
//   product        2*WIDTH-bit result, held until next completion
//   busy           high in CALC or DONE
module seq_array_multiplier #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [WIDTH:0]     sum;
  logic [CNT_W-1:0]   cnt;
  logic               last;
  logic [WIDTH-1:0]   a_ld;
  logic [WIDTH-1:0]   b_ld;

  assign last = (cnt == CNT_W'(WIDTH - 1));

`ifdef SEQ_MUL_SIGNED_EN
  logic neg;
  logic neg_ld;
  logic a_neg;
  logic b_neg;

  // Magnitudes; the most negative value maps to 2^(WIDTH-1),
  // which still fits as an unsigned WIDTH-bit number.
  assign a_neg  = is_signed & a[WIDTH-1];
  assign b_neg  = is_signed & b[WIDTH-1];
  assign a_ld   = a_neg ? (~a + 1'b1) : a;
  assign b_ld   = b_neg ? (~b + 1'b1) : b;
  assign neg_ld = a_neg ^ b_neg;
`else
  logic unused_is_signed;

  assign unused_is_signed = is_signed;
  assign a_ld = a;
  assign b_ld = b;
`endif

  // Add into the upper half with a carry bit, then shift the
  // {carry, acc} pair right; the multiplier drains out of the LSBs.
  always_comb begin
    sum = {1'b0, acc[2*WIDTH-1:WIDTH]};
    if (acc[0]) begin
      sum = sum + {1'b0, mcand};
    end
    acc_nxt = {sum, acc[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (in_valid) state_nxt = CALC;
      CALC: if (last) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand   <= '0;
      acc     <= '0;
      cnt     <= '0;
      product <= '0;
`ifdef SEQ_MUL_SIGNED_EN
      neg     <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            mcand <= a_ld;
            acc   <= {{WIDTH{1'b0}}, b_ld};
            cnt   <= '0;
`ifdef SEQ_MUL_SIGNED_EN
            neg   <= neg_ld;
`endif
          end
        end
        CALC: begin
          acc <= acc_nxt;
          cnt <= cnt + CNT_W'(1);
          if (last) begin
`ifdef SEQ_MUL_SIGNED_EN
            product <= neg ? (~acc_nxt + 1'b1) : acc_nxt;
`else
            product <= acc_nxt;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_array_multiplier.sv
// Directed bench for seq_array_multiplier (WIDTH=8 and WIDTH=4).
// Covers reset, latency, inputs held, backpressure, exhaustive 4-bit.
module tb_seq_array_multiplier;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        is_signed;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;
  logic        busy;

  logic        in_valid4;
  logic        in_ready4;
  logic [3:0]  a4;
  logic [3:0]  b4;
  logic        out_valid4;
  logic        out_ready4;
  logic [7:0]  product4;
  logic        busy4;

  int ncmp = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  seq_array_multiplier #(.WIDTH(8)) u8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .is_signed (is_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  seq_array_multiplier #(.WIDTH(4)) u4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid4),
    .in_ready  (in_ready4),
    .a         (a4),
    .b         (b4),
    .is_signed (1'b0),
    .out_valid (out_valid4),
    .out_ready (out_ready4),
    .product   (product4),
    .busy      (busy4)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Accept at the next edge, scramble inputs during CALC,
  // measure latency, check product, then complete the handshake.
  task automatic mul8(input string tag,
                      input logic [7:0] x,
                      input logic [7:0] y,
                      input logic s,
                      input logic [15:0] exp);
    int cyc;
    check({tag, " ready"}, in_ready, 1);
    in_valid = 1; a = x; b = y; is_signed = s;
    @(posedge clk); #1;
    in_valid = 0; a = ~x; b = ~y; is_signed = ~s;
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, " lat"}, cyc, 8);
    check({tag, " prod"}, product, exp);
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    check({tag, " idle"}, in_ready, 1);
  endtask

  initial begin
    int cyc;
    int nres;
    logic [7:0] exp4;

    rst_n = 0; in_valid = 0; a = 0; b = 0;
    is_signed = 0; out_ready = 0;
    in_valid4 = 0; a4 = 0; b4 = 0; out_ready4 = 0;
    #12;
    check("rst prod", product, 0);
    check("rst ovld", out_valid, 0);
    check("rst irdy", in_ready, 1);
    check("rst busy", busy, 0);
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;

    // reset mid-CALC
    in_valid = 1; a = 8'd200; b = 8'd3;
    @(posedge clk); #1;
    in_valid = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid busy", busy, 1);
    rst_n = 0; #1;
    check("mid prod", product, 0);
    check("mid ovld", out_valid, 0);
    check("mid irdy", in_ready, 1);
    check("mid busy0", busy, 0);
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;

    mul8("7x6", 8'd7, 8'd6, 0, 16'd42);
    mul8("ffxff", 8'hFF, 8'hFF, 0, 16'hFE01);
    mul8("0x9a", 8'h00, 8'h9A, 0, 16'h0000);
    mul8("80x2", 8'h80, 8'h02, 0, 16'h0100);

    // backpressure
    in_valid = 1; a = 8'd12; b = 8'd11;
    @(posedge clk); #1;
    in_valid = 0;
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("bp lat", cyc, 8);
    in_valid = 1; a = 8'd3; b = 8'd3;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("bp ovld", out_valid, 1);
      check("bp prod", product, 132);
      check("bp irdy", in_ready, 0);
    end
    in_valid = 0;
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    check("bp exit irdy", in_ready, 1);
    check("bp exit busy", busy, 0);
    check("bp hold prod", product, 132);
    @(posedge clk); #1;
    check("bp no accept", busy, 0);

`ifdef SEQ_MUL_SIGNED_EN
    mul8("s m128", 8'h80, 8'h80, 1, 16'h4000);
    mul8("s m3x5", 8'hFD, 8'h05, 1, 16'hFFF1);
    mul8("s 5xm3", 8'h05, 8'hFD, 1, 16'hFFF1);
    mul8("s m3xm3", 8'hFD, 8'hFD, 1, 16'h0009);
    mul8("u fdx5", 8'hFD, 8'h05, 0, 16'h04F1);
`else
    mul8("nosgn fdx5", 8'hFD, 8'h05, 1, 16'h04F1);
`endif

    // exhaustive 4-bit, back-to-back
    nres = 0;
    in_valid4 = 1; out_ready4 = 1;
    for (int i = 0; i < 256; i++) begin
      cyc = 0;
      while (!in_ready4 && cyc < 20) begin
        @(posedge clk); #1;
        cyc++;
      end
      a4 = 4'(i >> 4);
      b4 = 4'(i);
      exp4 = 8'(a4) * 8'(b4);
      @(posedge clk); #1;
      cyc = 0;
      while (!out_valid4 && cyc < 20) begin
        @(posedge clk); #1;
        cyc++;
      end
      if (out_valid4) nres++;
      check("x4 prod", product4, exp4);
    end
    in_valid4 = 0;
    check("x4 count", nres, 256);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule
